// File: rtl/read_scheduler_if.sv
// read_scheduler_if: count/score inputs, pop handshake and display outputs of the read scheduler
interface read_scheduler_if;
    logic             tick;
    logic [5:0]       RS;
    logic [5:0]       LS;
    logic [2:0]       L1, L2, L3, L4;
    logic [1:0]       data1, data2, data3, data4;
    logic [3:0]       pop;
    logic             pop_ack;
    logic [1:0]       disp;
    logic             disp_valid;
    logic             mode;
    logic [7:0]       read_cnt;
    logic             busy;
    logic             err;
    modport master (
        input  tick, RS, LS, L1, L2, L3, L4, data1, data2, data3, data4, pop_ack,
        output pop, disp, disp_valid, mode, read_cnt, busy, err
    );
    modport slave (
        output tick, RS, LS, L1, L2, L3, L4, data1, data2, data3, data4, pop_ack,
        input  pop, disp, disp_valid, mode, read_cnt, busy, err
    );
endinterface

// File: rtl/read_scheduler.sv
// read_scheduler: per-tick arbitration of four packet buffers with mode selection, aging and ack timeout
module read_scheduler #(
    parameter int AGE_LIMIT   = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input logic          clk,
    input logic          rst,
    read_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, ARB, WAIT} state_t;
    state_t state, state_n;
    logic [3:0][2:0] l_in, occ, age;
    logic [3:0][1:0] d_in;
    logic [2:0] best;
    logic [1:0] sel, gnt;
    logic [7:0] tmo;
    logic aged, hit, tmo_done;
    assign l_in = {bus.L4, bus.L3, bus.L2, bus.L1};
    assign d_in = {bus.data4, bus.data3, bus.data2, bus.data1};
    assign tmo_done = tmo == 8'(ACK_TIMEOUT - 1);
    assign bus.busy = state != IDLE;
    always_comb begin
        aged = 1'b0;
        sel = 2'd0;
        best = 3'd0;
        for (int i = 3; i >= 0; i--)
            if (occ[i] != 3'd0 && age[i] == 3'(AGE_LIMIT)) begin
                aged = 1'b1;
                sel = 2'(i);
            end
        // mode 1 lets later equal entries overwrite, so ties go to the highest index
        if (!aged)
            for (int i = 0; i < 4; i++)
                if (occ[i] != 3'd0 && (bus.mode ? occ[i] >= best : occ[i] > best)) begin
                    best = occ[i];
                    sel = 2'(i);
                end
        hit = aged || best != 3'd0;
        state_n = state == IDLE ? (bus.tick ? ARB : IDLE) :
                  state == ARB  ? (hit ? WAIT : IDLE) :
                  (bus.pop_ack || tmo_done) ? IDLE : WAIT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.pop <= '0;
            bus.disp <= '0;
            bus.disp_valid <= 1'b0;
            bus.mode <= 1'b0;
            bus.read_cnt <= '0;
            bus.err <= 1'b0;
            tmo <= '0;
            gnt <= '0;
            occ <= '0;
            age <= '0;
        end else begin
            state <= state_n;
            bus.disp_valid <= 1'b0;
            if (bus.tick && state != IDLE) bus.err <= 1'b1;
            unique case (state)
                IDLE: if (bus.tick) begin
                    bus.mode <= bus.RS >= bus.LS;
                    for (int i = 0; i < 4; i++) occ[i] <= l_in[i] > 3'd6 ? 3'd6 : l_in[i];
                end
                ARB: if (hit) begin
                    bus.pop <= 4'b1 << sel;
                    gnt <= sel;
                    tmo <= '0;
                end
                WAIT: if (bus.pop_ack) begin
                    bus.disp <= d_in[gnt];
                    bus.disp_valid <= 1'b1;
                    bus.read_cnt <= bus.read_cnt + 8'd1;
                    bus.pop <= '0;
                    for (int i = 0; i < 4; i++)
                        age[i] <= (2'(i) == gnt || occ[i] == 3'd0) ? 3'd0 :
                                  age[i] == 3'(AGE_LIMIT) ? age[i] : age[i] + 3'd1;
                end else if (tmo_done) begin
                    bus.pop <= '0;
                    bus.err <= 1'b1;
                end else begin
                    tmo <= tmo + 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/read_scheduler.md
# read_scheduler

Arbitration controller that decides, once per service tick, which of the four 6-entry packet buffers gives up its head packet to the display. It replaces the free-running divided-clock read loop with an explicit enable-driven FSM. The FSM chooses between latency mode and reliability mode using the score unit's outputs, and adds an aging rule so that no non-empty buffer starves. It sits between the count/score units (its inputs) and the buffer shift logic and display (its outputs).

## Interface
- AGE_LIMIT, 4: consecutive skips after which a non-empty buffer is forced to win; range 1..7.
- ACK_TIMEOUT, 15: cycles to wait for pop_ack before the pop is abandoned; range 1..255.

- clk  in  1  system clock (50 MHz); the only clock.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  one-cycle service strobe from freqdivider (one every 3 s in the system).
- RS  in  6  reliability score.
- LS  in  6  latency score.
- L1..L4  in  3 each  occupancy of buffers 1..4; valid range 0..6.
- data1..data4  in  2 each  head payload of buffers 1..4, taken from bits [2:1] of entry 0.
- pop  out  4  one-hot shift request; bit k-1 corresponds to buffer k.
- pop_ack  in  1  buffer logic has shifted the granted buffer.
- disp  out  2  last payload that was read.
- disp_valid  out  1  one-cycle pulse when disp updates.
- mode  out  1  0 = latency, 1 = reliability; latched at tick.
- read_cnt  out  8  number of completed reads; wraps from 255 to 0.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky flag, set by an ack timeout or by a tick that arrives while busy.

## Operation
- States are IDLE, ARB, WAIT. Reset forces IDLE.
- Reset values: pop=0, disp=0, disp_valid=0, mode=0, read_cnt=0, busy=0, err=0, all ages=0, timeout counter=0.
- IDLE, tick=1: latch mode = (RS >= LS), latch L1..L4 into occ1..occ4, go to ARB.
- ARB, grant selection in priority order:
  - Aging: any buffer with occ>0 and age==AGE_LIMIT wins; the lowest index wins among several.
  - Otherwise mode 0: the non-empty buffer with the largest occ wins; ties go to the lowest index.
  - Otherwise mode 1: the non-empty buffer with the largest occ wins; ties go to the highest index.
  - All occ=0: no grant, ages unchanged, return to IDLE.
  - With a grant: drive pop one-hot, clear the timeout counter, go to WAIT.
- WAIT: pop stays constant and the timeout counter increments each cycle.
  - pop_ack=1: disp = data of the granted buffer, sampled in the ack cycle. Then pulse disp_valid, increment read_cnt, update ages, drop pop, go to IDLE.
  - Timeout counter reaches ACK_TIMEOUT with no ack: drop pop, set err, leave ages and read_cnt unchanged, go to IDLE.
- Age update, applied only on a completed read:
  - Granted buffer: age=0.
  - Other buffers with occ>0: age+1, saturating at AGE_LIMIT.
  - Buffers with occ=0: age=0.
- A tick seen in ARB or WAIT is ignored for scheduling and sets err.
- pop_ack seen outside WAIT is ignored.
- Occupancy values above 6 are treated as 6.

## Timing
- tick at cycle t gives ARB at t+1, pop asserted from t+2, mode valid from t+1.
- pop_ack at cycle a gives disp, disp_valid, read_cnt and age updates visible at a+1, pop=0 at a+1, IDLE at a+1.
- Fastest read: tick at t, ack at t+2, disp_valid at t+3.
- Timeout: pop is high for exactly ACK_TIMEOUT cycles; err rises the cycle pop falls.
- rst has priority over everything. Asserted mid-WAIT, it drops pop and returns all outputs to reset values on the next edge.
- A tick in the same cycle rst is deasserted is ignored; the first tick that can be accepted is one cycle after rst is low.

## Test plan
- Mode 0 selection:
  - Stimulus: rst, then L=(3,5,5,1), RS=10, LS=20, tick, ack 2 cycles after pop, data2=2'b10.
  - Required: mode=0, pop=4'b0010, disp=2'b10, disp_valid for 1 cycle, read_cnt=1.
- Mode 1 tie:
  - Stimulus: L=(6,2,2,6), RS=20, LS=20, tick.
  - Required: mode=1, pop=4'b1000.
- Aging (AGE_LIMIT=4):
  - Stimulus: L=(6,1,0,0), mode 0, ack every read, five ticks.
  - Required: reads 1–4 grant buffer 1; read 5 grants buffer 2 (pop=4'b0010), and buffer 2's age returns to 0.
- Empty and timeout:
  - Stimulus: all L=0 and a tick; then L=(1,0,0,0), a tick and no ack.
  - Required: the first tick never raises pop and leaves busy low after ARB. The second tick holds pop=4'b0001 for 15 cycles, then err=1 and read_cnt is unchanged.
- Overrun and reset:
  - Stimulus: a tick during WAIT; then rst mid-WAIT.
  - Required: err=1 after the tick with the grant unchanged; after rst, pop=0, busy=0, err=0, read_cnt=0 on the next edge.
- Wrap:
  - Stimulus: 256 completed reads.
  - Required: read_cnt returns to 0.
